// File: rtl/count_cycle_sched.sv
// Frame-boundary scheduler in front of count_cycle_cw16_8: owns cnt_limit/sync_reset and gates the input stream.
// Zero-cycle data path; new frame lengths are applied only after every in-flight frame has drained.
module count_cycle_sched #(
  parameter int DATA_WIDTH  = 32,
  parameter int OUTST_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  async_reset_n,
  input  logic                  cfg_tvalid,
  output logic                  cfg_tready,
  input  logic [15:0]           cfg_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  output logic                  c_axis_tvalid,
  input  logic                  c_axis_tready,
  output logic [DATA_WIDTH-1:0] c_axis_tdata,
  output logic [15:0]           cnt_limit,
  output logic                  cnt_sync_reset,
  input  logic                  mon_final,
  output logic                  busy,
  output logic [15:0]           frame_count
);

  typedef enum logic [1:0] {IDLE, RUN, HOLD, LOAD} state_t;

  state_t                 state;
  logic [15:0]            pend_limit;
  logic                   pend;
  logic [15:0]            rem;
  logic [OUTST_WIDTH-1:0] outst;
  logic [0:0]             lcnt;

  logic at_start, gate, cfg_hs, take, frame_end, final_ok;

  assign at_start  = (rem == cnt_limit);
  assign gate      = (state == RUN) && !(pend && at_start) && !(&outst);
  assign cfg_tready = ~pend;
  assign cfg_hs    = cfg_tvalid & ~pend;

  assign c_axis_tvalid = s_axis_tvalid & gate;
  assign s_axis_tready = c_axis_tready & gate;
  assign c_axis_tdata  = s_axis_tdata;

  assign take      = s_axis_tvalid & s_axis_tready;
  assign frame_end = take && (rem == 16'd0);
  // A final flag with nothing outstanding is spurious and must not underflow the count.
  assign final_ok  = mon_final && (outst != '0);
  assign busy      = (state != RUN);

  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      state          <= IDLE;
      pend_limit     <= 16'd0;
      pend           <= 1'b0;
      rem            <= 16'd0;
      outst          <= '0;
      lcnt           <= 1'b0;
      cnt_limit      <= 16'd0;
      cnt_sync_reset <= 1'b1;
      frame_count    <= 16'd0;
    end else begin
      if (cfg_hs) begin
        pend       <= 1'b1;
        pend_limit <= cfg_tdata;
      end

      if (take) rem <= (rem == 16'd0) ? cnt_limit : rem - 16'd1;

      case ({frame_end, final_ok})
        2'b10:   outst <= outst + 1'b1;
        2'b01:   outst <= outst - 1'b1;
        default: outst <= outst;
      endcase

      if (final_ok) frame_count <= frame_count + 16'd1;

      // LOAD entry overrides the per-cycle updates above; no take or cfg can coincide with it.
      case (state)
        IDLE: begin
          cnt_sync_reset <= 1'b1;
          if (pend) begin
            state          <= LOAD;
            cnt_limit      <= pend_limit;
            rem            <= pend_limit;
            pend           <= 1'b0;
            frame_count    <= 16'd0;
            lcnt           <= 1'b0;
          end
        end
        RUN: begin
          if (pend && at_start) state <= HOLD;
        end
        HOLD: begin
          if ((outst == '0) && !mon_final) begin
            state          <= LOAD;
            cnt_limit      <= pend_limit;
            rem            <= pend_limit;
            pend           <= 1'b0;
            frame_count    <= 16'd0;
            lcnt           <= 1'b0;
            cnt_sync_reset <= 1'b1;
          end
        end
        LOAD: begin
          lcnt <= lcnt + 1'b1;
          if (lcnt == 1'b1) begin
            state          <= RUN;
            cnt_sync_reset <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_count_cycle_sched.sv
// Directed bench for count_cycle_sched; the counter's final flag is driven by hand.
module tb_count_cycle_sched;

  logic        clk = 1'b0;
  logic        async_reset_n;
  logic        cfg_tvalid;
  logic        cfg_tready;
  logic [15:0] cfg_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [31:0] s_axis_tdata;
  logic        c_axis_tvalid;
  logic        c_axis_tready;
  logic [31:0] c_axis_tdata;
  logic [15:0] cnt_limit;
  logic        cnt_sync_reset;
  logic        mon_final;
  logic        busy;
  logic [15:0] frame_count;

  int errors = 0;
  int checks = 0;
  logic [31:0] data_seq = 32'h1000;

  always #5 clk = ~clk;

  count_cycle_sched #(.DATA_WIDTH(32), .OUTST_WIDTH(4)) dut (
    .clk(clk), .async_reset_n(async_reset_n),
    .cfg_tvalid(cfg_tvalid), .cfg_tready(cfg_tready), .cfg_tdata(cfg_tdata),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
    .c_axis_tvalid(c_axis_tvalid), .c_axis_tready(c_axis_tready), .c_axis_tdata(c_axis_tdata),
    .cnt_limit(cnt_limit), .cnt_sync_reset(cnt_sync_reset), .mon_final(mon_final),
    .busy(busy), .frame_count(frame_count)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Offers up to n samples within max_cyc cycles; returns how many were taken.
  task automatic send(input int n, input int max_cyc, output int taken);
    int cyc = 0;
    taken = 0;
    s_axis_tvalid = 1'b1;
    while (taken < n && cyc < max_cyc) begin
      s_axis_tdata = data_seq;
      #1;
      if (s_axis_tready) begin
        checks++;
        if (c_axis_tvalid !== 1'b1 || c_axis_tdata !== s_axis_tdata) begin
          errors++;
          $display("FAIL passthrough: c_axis_tvalid=%0b c_axis_tdata=%h, required 1 and %h",
                   c_axis_tvalid, c_axis_tdata, s_axis_tdata);
        end
        taken++;
        data_seq++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    s_axis_tvalid = 1'b0;
  endtask

  task automatic do_cfg(input logic [15:0] l);
    int cyc = 0;
    cfg_tvalid = 1'b1;
    cfg_tdata  = l;
    #1;
    while (!cfg_tready && cyc < 20) begin
      tick();
      cyc++;
    end
    checks++;
    if (!cfg_tready) begin
      errors++;
      $display("FAIL cfg_accept: cfg_tready=0 after %0d cycles, required 1", cyc);
    end
    tick();
    cfg_tvalid = 1'b0;
  endtask

  task automatic wait_run;
    int cyc = 0;
    while (busy && cyc < 10) begin
      tick();
      cyc++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL wait_run: busy=%0b after %0d cycles, required 0", busy, cyc);
    end
  endtask

  task automatic pulse_final(input int n);
    for (int i = 0; i < n; i++) begin
      mon_final = 1'b1;
      tick();
      mon_final = 1'b0;
    end
  endtask

  task automatic test_reset;
    int bad = 0;
    async_reset_n = 1'b0;
    s_axis_tvalid = 1'b1;
    #2;
    checks++;
    if (cnt_sync_reset !== 1'b1 || busy !== 1'b1 || cfg_tready !== 1'b1 || s_axis_tready !== 1'b0 ||
        c_axis_tvalid !== 1'b0 || cnt_limit !== 16'd0 || frame_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_values: sr=%0b busy=%0b cfg_rdy=%0b s_rdy=%0b c_vld=%0b lim=%0d fc=%0d, required 1 1 1 0 0 0 0",
               cnt_sync_reset, busy, cfg_tready, s_axis_tready, c_axis_tvalid, cnt_limit, frame_count);
    end
    tick();
    tick();
    async_reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (cnt_sync_reset !== 1'b1 || busy !== 1'b1 || s_axis_tready !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL idle_hold: %0d of 20 cycles left IDLE outputs, required 0", bad);
    end
    s_axis_tvalid = 1'b0;
  endtask

  task automatic test_cfg_latency;
    cfg_tvalid = 1'b1;
    cfg_tdata  = 16'd3;
    tick();
    cfg_tvalid = 1'b0;
    checks++;
    if (cfg_tready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL lat_n1: cfg_tready=%0b busy=%0b, required 0 1", cfg_tready, busy);
    end
    tick();
    checks++;
    if (cnt_limit !== 16'd3 || cnt_sync_reset !== 1'b1) begin
      errors++;
      $display("FAIL lat_n2: cnt_limit=%0d sync_reset=%0b, required 3 1", cnt_limit, cnt_sync_reset);
    end
    tick();
    checks++;
    if (cnt_sync_reset !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL lat_n3: sync_reset=%0b busy=%0b, required 1 1", cnt_sync_reset, busy);
    end
    tick();
    s_axis_tvalid = 1'b1;
    #1;
    checks++;
    if (cnt_sync_reset !== 1'b0 || busy !== 1'b0 || s_axis_tready !== 1'b1) begin
      errors++;
      $display("FAIL lat_n4: sync_reset=%0b busy=%0b s_rdy=%0b, required 0 0 1",
               cnt_sync_reset, busy, s_axis_tready);
    end
    s_axis_tvalid = 1'b0;
    tick();
  endtask

  task automatic test_stream;
    int taken;
    send(8, 20, taken);
    checks++;
    if (taken != 8) begin
      errors++;
      $display("FAIL stream_taken: %0d, required 8", taken);
    end
    pulse_final(2);
    checks++;
    if (frame_count !== 16'd2) begin
      errors++;
      $display("FAIL stream_frames: frame_count=%0d, required 2", frame_count);
    end
    pulse_final(1);
    checks++;
    if (frame_count !== 16'd2) begin
      errors++;
      $display("FAIL underflow: frame_count=%0d, required 2", frame_count);
    end
  endtask

  task automatic test_midframe;
    int taken;
    do_cfg(16'd7);
    tick();
    wait_run();
    checks++;
    if (cnt_limit !== 16'd7 || frame_count !== 16'd0) begin
      errors++;
      $display("FAIL reload7: cnt_limit=%0d frame_count=%0d, required 7 0", cnt_limit, frame_count);
    end
    send(3, 10, taken);
    do_cfg(16'd2);
    send(10, 20, taken);
    checks++;
    if (taken != 5) begin
      errors++;
      $display("FAIL midframe_tail: %0d samples passed, required 5", taken);
    end
    pulse_final(1);
    wait_run();
    checks++;
    if (cnt_limit !== 16'd2) begin
      errors++;
      $display("FAIL midframe_limit: cnt_limit=%0d, required 2", cnt_limit);
    end
  endtask

  task automatic test_boundary;
    int taken;
    send(2, 10, taken);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = data_seq;
    cfg_tvalid    = 1'b1;
    cfg_tdata     = 16'd1;
    #1;
    checks++;
    if (s_axis_tready !== 1'b1 || cfg_tready !== 1'b1) begin
      errors++;
      $display("FAIL collide_rdy: s_rdy=%0b cfg_rdy=%0b, required 1 1", s_axis_tready, cfg_tready);
    end
    tick();
    cfg_tvalid = 1'b0;
    data_seq++;
    s_axis_tdata = data_seq;
    #1;
    checks++;
    if (s_axis_tready !== 1'b0 || c_axis_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL collide_gate: s_rdy=%0b c_vld=%0b, required 0 0", s_axis_tready, c_axis_tvalid);
    end
    tick();
    tick();
    checks++;
    if (busy !== 1'b1 || cnt_sync_reset !== 1'b0 || s_axis_tready !== 1'b0) begin
      errors++;
      $display("FAIL collide_hold: busy=%0b sync_reset=%0b s_rdy=%0b, required 1 0 0",
               busy, cnt_sync_reset, s_axis_tready);
    end
    s_axis_tvalid = 1'b0;
    pulse_final(1);
    wait_run();
    checks++;
    if (cnt_limit !== 16'd1) begin
      errors++;
      $display("FAIL collide_limit: cnt_limit=%0d, required 1", cnt_limit);
    end
  endtask

  task automatic test_backpressure;
    int taken;
    do_cfg(16'd0);
    tick();
    wait_run();
    c_axis_tready = 1'b0;
    s_axis_tvalid = 1'b1;
    #1;
    checks++;
    if (s_axis_tready !== 1'b0 || c_axis_tvalid !== 1'b1) begin
      errors++;
      $display("FAIL bp_stall: s_rdy=%0b c_vld=%0b, required 0 1", s_axis_tready, c_axis_tvalid);
    end
    s_axis_tvalid = 1'b0;
    c_axis_tready = 1'b1;
    tick();
    send(20, 30, taken);
    checks++;
    if (taken != 15) begin
      errors++;
      $display("FAIL bp_saturate: %0d samples passed, required 15", taken);
    end
    pulse_final(15);
    checks++;
    if (frame_count !== 16'd15) begin
      errors++;
      $display("FAIL bp_drain: frame_count=%0d, required 15", frame_count);
    end
    send(5, 10, taken);
    pulse_final(5);
    checks++;
    if (taken != 5 || frame_count !== 16'd20) begin
      errors++;
      $display("FAIL bp_resume: taken=%0d frame_count=%0d, required 5 20", taken, frame_count);
    end
  endtask

  task automatic test_async_reset;
    int taken;
    do_cfg(16'd5);
    tick();
    wait_run();
    send(3, 10, taken);
    s_axis_tvalid = 1'b1;
    async_reset_n = 1'b0;
    #1;
    checks++;
    if (cnt_sync_reset !== 1'b1 || busy !== 1'b1 || cnt_limit !== 16'd0 || frame_count !== 16'd0 ||
        cfg_tready !== 1'b1 || s_axis_tready !== 1'b0 || c_axis_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: sr=%0b busy=%0b lim=%0d fc=%0d cfg_rdy=%0b s_rdy=%0b c_vld=%0b, required 1 1 0 0 1 0 0",
               cnt_sync_reset, busy, cnt_limit, frame_count, cfg_tready, s_axis_tready, c_axis_tvalid);
    end
    s_axis_tvalid = 1'b0;
    tick();
    tick();
    async_reset_n = 1'b1;
    tick();
    tick();
    do_cfg(16'd5);
    tick();
    wait_run();
    send(5, 10, taken);
    do_cfg(16'd5);
    send(10, 15, taken);
    checks++;
    if (taken != 1) begin
      errors++;
      $display("FAIL post_reset_frame: %0d samples passed, required 1", taken);
    end
  endtask

  initial begin
    async_reset_n = 1'b0;
    cfg_tvalid    = 1'b0;
    cfg_tdata     = 16'd0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = 32'd0;
    c_axis_tready = 1'b1;
    mon_final     = 1'b0;
    tick();
    test_reset();
    test_cfg_latency();
    test_stream();
    test_midframe();
    test_boundary();
    test_backpressure();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/count_cycle_sched.md
# count_cycle_sched

Frame-boundary scheduler that sits directly in front of the `count_cycle_cw16_8` counter/alignment block. It owns that block's `cnt_limit` and `sync_reset` and gates its input stream. Frame-length changes are therefore applied only at frame boundaries, after every in-flight frame has drained out of the counter's pipeline and FIFO. This prevents the partial-nibble count corruption that occurs when `cnt_limit` changes mid-frame.

## Interface
- DATA_WIDTH, 32, sample width passed through to the counter block
- OUTST_WIDTH, 4, width of the outstanding-frame counter; maximum outstanding frames is 2^OUTST_WIDTH-1
- clk  in  1  sole clock
- async_reset_n  in  1  asynchronous, active-low reset
- cfg_tvalid / cfg_tready  in / out  1 / 1  frame-length config handshake
- cfg_tdata  in  16  new limit L; frame length = L+1 samples
- s_axis_tvalid / s_axis_tready  in / out  1 / 1  upstream sample stream
- s_axis_tdata  in  DATA_WIDTH  upstream samples
- c_axis_tvalid / c_axis_tready  out / in  1 / 1  to the counter's `s_axis`
- c_axis_tdata  out  DATA_WIDTH  to the counter's `s_axis_tdata`
- cnt_limit  out  16  to the counter's `cnt_limit`; registered
- cnt_sync_reset  out  1  to the counter's `sync_reset`; registered
- mon_final  in  1  counter output handshake with final flag: `m_axis_tvalid & m_axis_tready & m_axis_final_cnt`
- busy  out  1  high in any state other than RUN
- frame_count  out  16  completed frames observed on mon_final; wraps modulo 2^16; cleared on LOAD

## Operation
- States: IDLE, RUN, HOLD, LOAD.
- Registers:
  - `pend_limit[15:0]` and `pend`: config accepted but not yet applied.
  - `rem[15:0]`: samples remaining in the current input frame, minus 1.
  - `outst[OUTST_WIDTH-1:0]`: frames fully sent into the counter but not yet seen on mon_final.
  - `lcnt[0]`: LOAD cycle counter.
- `cfg_tready = ~pend`. A cfg handshake sets `pend=1` and `pend_limit=cfg_tdata`.
- `at_start = (rem == cnt_limit)`.
- `gate = (state==RUN) & ~(pend & at_start) & (outst != max)`.
- `c_axis_tvalid = s_axis_tvalid & gate`. `s_axis_tready = c_axis_tready & gate`. `c_axis_tdata = s_axis_tdata`, combinational pass-through.
- `take = s_axis_tvalid & s_axis_tready`.
- On take:
  - If `rem == 0`: `rem <= cnt_limit`, and `outst` increments (end of frame).
  - Otherwise `rem <= rem - 1`.
- On mon_final: `outst` decrements and `frame_count` increments.
- Simultaneous increment and decrement leave `outst` unchanged.
- `outst` never underflows: a mon_final while `outst==0` is ignored and does not count.
- State transitions:
  - IDLE: `cnt_sync_reset=1`. Go to LOAD when `pend`.
  - RUN: go to HOLD when `pend & at_start`. This includes the cycle after the last sample of a frame is taken.
  - HOLD: `gate=0`. Go to LOAD when `outst==0 & ~mon_final`.
  - LOAD: on entry, `cnt_limit <= pend_limit`, `rem <= pend_limit`, `pend <= 0`, `frame_count <= 0`. Hold `cnt_sync_reset=1` for exactly 2 cycles, then go to RUN with `cnt_sync_reset=0`.
- A cfg arriving in the same cycle as a frame-ending take is accepted; the block enters HOLD on the following cycle.
- A cfg accepted mid-frame waits until that frame completes. Data is never cut mid-frame.
- L=0 is legal: each sample is its own frame and `outst` increments on every take.

## Timing
- Reset values:
  - State IDLE; `cnt_sync_reset=1`; `cnt_limit=0`.
  - `rem=0`, `outst=0`, `pend=0`, `frame_count=0`.
  - `busy=1`; `cfg_tready=1`; `s_axis_tready=0`; `c_axis_tvalid=0`.
- Reset is asynchronous on assertion. Deassertion is sampled on the next clk edge.
- Reset mid-frame drops all in-flight state. The counter is held in sync_reset until a new config arrives.
- Data path latency is zero cycles: a combinational pass-through to the counter block.
- Config-to-first-sample latency from IDLE: cfg handshake at cycle n, LOAD at cycles n+2 and n+3, RUN with `s_axis_tready` able to rise at n+4.
- `cnt_limit` changes only on entry to LOAD, while `cnt_sync_reset` is high. It is stable for at least 2 cycles before `cnt_sync_reset` falls.
- `busy` is registered with the state: it follows the state register.

## Test plan
- Startup: with reset released, `cnt_sync_reset` and `busy` stay 1 and `s_axis_tready=0` for 20 cycles. Then cfg L=3 → `cnt_sync_reset` high 2 more cycles; stream 8 samples → counter output shows 2 frames, `frame_count=2`.
- Mid-frame reconfig: L=7 running, cfg L=2 after the 3rd sample of a frame → 5 further samples pass; `s_axis_tready` drops; after the final flag drains, LOAD of 2 cycles; subsequent frames are 3 samples long.
- Boundary collision: cfg handshake in the same cycle as the frame-ending take → no extra sample passes; HOLD on the next cycle; LOAD once `outst==0`.
- Backpressure: L=0 with the counter's downstream tready=0 → `outst` saturates at 15 or the counter's `almost_full` stalls input. No sample is lost and `frame_count` equals the number of samples once drained.
- Async reset asserted mid-frame (L=5, 3 samples in) → all outputs return to their reset values immediately; the next cfg L=5 gives clean 6-sample frames.
- Random valid/ready with 10 random reconfigs → every frame observed at the counter output has length = limit+1 of the config in effect when that frame started.
